// File: rtl/fp_minmax_reduce.sv
// Streaming FP min/max reducer: tracks the frame minimum and maximum with their
// element indices, plus saturating element and NaN counts, over a valid/ready stream.
module fp_minmax_reduce #(
  parameter int sig_width       = 23,
  parameter int exp_width       = 8,
  parameter int ieee_compliance = 0,
  parameter int idx_width       = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [sig_width+exp_width:0]    in_data,
  input  logic                            in_last,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [sig_width+exp_width:0]    min_z,
  output logic [sig_width+exp_width:0]    max_z,
  output logic [idx_width-1:0]            min_idx,
  output logic [idx_width-1:0]            max_idx,
  output logic [idx_width-1:0]            count,
  output logic [idx_width-1:0]            nan_count,
  output logic                            all_nan
);

  localparam int W = sig_width + exp_width + 1;
  localparam logic [W-1:0] QNAN = {1'b0, {exp_width{1'b1}}, 1'b1, {(sig_width-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t state;
  logic   have_val;

  // Magnitude used for ordering; without IEEE handling denormals collapse to zero.
  function automatic logic [W-2:0] mag(input logic [W-1:0] v);
    if (ieee_compliance == 0 && v[W-2:sig_width] == '0) return '0;
    return v[W-2:0];
  endfunction

  function automatic logic less(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-2:0] ma, mb;
    logic sa, sb;
    ma = mag(a);
    mb = mag(b);
    sa = a[W-1] && (ma != '0);
    sb = b[W-1] && (mb != '0);
    if (sa != sb) return sa;
    return sa ? (ma > mb) : (ma < mb);
  endfunction

  function automatic logic [idx_width-1:0] inc_sat(input logic [idx_width-1:0] v);
    return (&v) ? v : v + {{(idx_width-1){1'b0}}, 1'b1};
  endfunction

  logic                 accept, first, have_eff, in_nan, take_min, take_max;
  logic [idx_width-1:0] elem_idx, nan_base;

  // Accepting in IDLE opens a fresh frame, so previous results are ignored.
  assign accept   = in_valid & in_ready;
  assign first    = (state == IDLE);
  assign have_eff = !first && have_val;
  assign elem_idx = first ? '0 : count;
  assign nan_base = first ? '0 : nan_count;
  assign in_nan   = (ieee_compliance != 0) && (&in_data[W-2:sig_width]) &&
                    (|in_data[sig_width-1:0]);
  assign take_min = !have_eff || less(in_data, min_z);
  assign take_max = !have_eff || less(max_z, in_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      have_val  <= 1'b0;
      min_z     <= '0;
      max_z     <= '0;
      min_idx   <= '0;
      max_idx   <= '0;
      count     <= '0;
      nan_count <= '0;
      all_nan   <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            count     <= inc_sat(elem_idx);
            nan_count <= in_nan ? inc_sat(nan_base) : nan_base;
            have_val  <= have_eff | ~in_nan;
            if (in_nan) begin
              // Canonical qNaN holds the slot until a real value arrives; it remains for all-NaN frames.
              if (!have_eff) begin
                min_z   <= QNAN;
                max_z   <= QNAN;
                min_idx <= '0;
                max_idx <= '0;
              end
            end else begin
              if (take_min) begin
                min_z   <= in_data;
                min_idx <= elem_idx;
              end
              if (take_max) begin
                max_z   <= in_data;
                max_idx <= elem_idx;
              end
            end
            if (in_last) begin
              state     <= HOLD;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              all_nan   <= in_nan && !have_eff;
            end else begin
              state   <= ACCUM;
              all_nan <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_minmax_reduce.sv
// Scoreboard bench for fp_minmax_reduce: two instances (IEEE-unaware with wide counters,
// IEEE-aware with 4-bit counters) share one stimulus stream and are checked against a key-based model.
module tb_fp_minmax_reduce;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] in_data = '0;

  logic        rdy0, ov0, an0;
  logic [31:0] min0, max0;
  logic [15:0] mni0, mxi0, cnt0, nc0;

  logic        rdy1, ov1, an1;
  logic [31:0] min1, max1;
  logic [3:0]  mni1, mxi1, cnt1, nc1;

  localparam logic [31:0] QNAN = 32'h7FC00000;
  localparam int MAX0 = 65535;
  localparam int MAX1 = 15;

  typedef struct {
    logic [31:0] mn;
    logic [31:0] mx;
    int          mni;
    int          mxi;
    int          cnt;
    int          nc;
    bit          an;
  } res_t;

  res_t        q0[$];
  res_t        q1[$];
  logic [31:0] frame[$];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  fp_minmax_reduce #(.sig_width(23), .exp_width(8), .ieee_compliance(0), .idx_width(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
    .in_last(in_last), .out_valid(ov0), .out_ready(out_ready), .min_z(min0), .max_z(max0),
    .min_idx(mni0), .max_idx(mxi0), .count(cnt0), .nan_count(nc0), .all_nan(an0));

  fp_minmax_reduce #(.sig_width(23), .exp_width(8), .ieee_compliance(1), .idx_width(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
    .in_last(in_last), .out_valid(ov1), .out_ready(out_ready), .min_z(min1), .max_z(max1),
    .min_idx(mni1), .max_idx(mxi1), .count(cnt1), .nan_count(nc1), .all_nan(an1));

  task checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Signed ordering key: magnitude with the sign applied, so +0 and -0 coincide.
  function automatic longint keyOf(input logic [31:0] v, input bit ieee);
    longint m;
    m = (!ieee && v[30:23] == 8'h00) ? 64'sd0 : longint'(v[30:0]);
    return v[31] ? -m : m;
  endfunction

  function automatic res_t model(input bit ieee, input int maxidx);
    res_t   r;
    bit     have;
    longint k, kmin, kmax;
    int     idx;
    have = 0; kmin = 0; kmax = 0;
    r.mn = '0; r.mx = '0; r.mni = 0; r.mxi = 0; r.nc = 0;
    for (int i = 0; i < frame.size(); i++) begin
      idx = (i > maxidx) ? maxidx : i;
      if (ieee && frame[i][30:23] == 8'hFF && frame[i][22:0] != 0) begin
        if (r.nc < maxidx) r.nc++;
        continue;
      end
      k = keyOf(frame[i], ieee);
      if (!have || k < kmin) begin kmin = k; r.mn = frame[i]; r.mni = idx; end
      if (!have || k > kmax) begin kmax = k; r.mx = frame[i]; r.mxi = idx; end
      have = 1;
    end
    r.cnt = (frame.size() > maxidx) ? maxidx : frame.size();
    if (!have) begin r.mn = QNAN; r.mx = QNAN; r.mni = 0; r.mxi = 0; end
    r.an = ieee && !have;
    return r;
  endfunction

  function automatic logic [31:0] randElem();
    logic [31:0] pool [4];
    pool[0] = 32'h3F800000; pool[1] = 32'hBF800000; pool[2] = 32'h40000000; pool[3] = 32'h00000001;
    case ($urandom_range(0, 7))
      0:       return $urandom;
      1:       return {1'($urandom_range(0, 1)), 31'h0};
      2:       return {1'($urandom_range(0, 1)), 8'h00, 23'($urandom_range(1, 8))};
      3:       return {1'($urandom_range(0, 1)), 8'hFF, 23'h0};
      4:       return {1'($urandom_range(0, 1)), 8'hFF, 23'($urandom_range(1, 'h7FFFFF))};
      default: return pool[$urandom_range(0, 3)];
    endcase
  endfunction

  // Present one operand and hold it until both instances take it.
  task sendOne(input logic [31:0] d, input bit last, output int waits);
    bit rd;
    rd = 0;
    waits = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!rd && waits < 200) begin
      @(negedge clk);
      rd = rdy0 && rdy1;
      waits++;
    end
    if (!rd) begin
      errors++; checks++;
      $display("[TB] FAIL accept timeout: got in_ready=%b/%b expected 1", rdy0, rdy1);
    end
    @(posedge clk);
    #1;
  endtask

  task applyStimulus(output int firstWait);
    int w;
    firstWait = 0;
    for (int i = 0; i < frame.size(); i++) begin
      sendOne(frame[i], i == frame.size() - 1, w);
      if (i == 0) firstWait = w;
    end
    q0.push_back(model(0, MAX0));
    q1.push_back(model(1, MAX1));
    in_valid = 1'b0;
    in_last  = 1'b0;
    checkOutput("out_valid after last dut0", 32'(ov0), 32'd1);
    checkOutput("out_valid after last dut1", 32'(ov1), 32'd1);
  endtask

  task checkIdle(input string tag);
    checkOutput({tag, " in_ready"},  32'(rdy0), 32'd1);
    checkOutput({tag, " out_valid"}, 32'(ov0),  32'd0);
    checkOutput({tag, " min_z"},     min0, 32'd0);
    checkOutput({tag, " max_z"},     max0, 32'd0);
    checkOutput({tag, " idx"},       32'({mni0, mxi0}), 32'd0);
    checkOutput({tag, " count"},     32'({cnt0, nc0}), 32'd0);
    checkOutput({tag, " dut1 ctl"},  32'({rdy1, ov1, an1}), 32'b100);
    checkOutput({tag, " dut1 data"}, min1 | max1, 32'd0);
    checkOutput({tag, " dut1 cnt"},  32'({mni1, mxi1, cnt1, nc1}), 32'd0);
  endtask

  // Monitor: compare each result as it is handed over.
  always @(negedge clk) begin
    res_t e;
    if (rst_n && ov0 && out_ready) begin
      if (q0.size() == 0) begin
        errors++; checks++;
        $display("[TB] FAIL dut0 unexpected result: got min=%h expected none", min0);
      end else begin
        e = q0.pop_front();
        checkOutput("dut0 min_z", min0, e.mn);
        checkOutput("dut0 max_z", max0, e.mx);
        checkOutput("dut0 min_idx", 32'(mni0), 32'(e.mni));
        checkOutput("dut0 max_idx", 32'(mxi0), 32'(e.mxi));
        checkOutput("dut0 count", 32'(cnt0), 32'(e.cnt));
        checkOutput("dut0 nan_count", 32'(nc0), 32'(e.nc));
        checkOutput("dut0 all_nan", 32'(an0), 32'(e.an));
        checkOutput("dut0 in_ready hold", 32'(rdy0), 32'd0);
      end
    end
    if (rst_n && ov1 && out_ready) begin
      if (q1.size() == 0) begin
        errors++; checks++;
        $display("[TB] FAIL dut1 unexpected result: got min=%h expected none", min1);
      end else begin
        e = q1.pop_front();
        checkOutput("dut1 min_z", min1, e.mn);
        checkOutput("dut1 max_z", max1, e.mx);
        checkOutput("dut1 min_idx", 32'(mni1), 32'(e.mni));
        checkOutput("dut1 max_idx", 32'(mxi1), 32'(e.mxi));
        checkOutput("dut1 count", 32'(cnt1), 32'(e.cnt));
        checkOutput("dut1 nan_count", 32'(nc1), 32'(e.nc));
        checkOutput("dut1 all_nan", 32'(an1), 32'(e.an));
        checkOutput("dut1 in_ready hold", 32'(rdy1), 32'd0);
      end
    end
  end

  initial begin
    int w, g;
    repeat (3) @(posedge clk);
    #1;
    checkIdle("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    frame = '{32'h3F800000, 32'hC0000000, 32'h40400000, 32'h3F000000};
    applyStimulus(w);
    frame = '{32'h00000000, 32'h80000000};
    applyStimulus(w);
    for (int i = 0; i < 3; i++) begin
      frame = '{32'h41200000};
      applyStimulus(w);
    end
    frame = '{32'h7FC00000, 32'h3F800000, 32'h7F800001};
    applyStimulus(w);
    frame = '{32'h7FC00000, 32'h7F800001, 32'hFF800100};
    applyStimulus(w);

    frame.delete();
    for (int i = 0; i < 20; i++) frame.push_back(randElem());
    applyStimulus(w);

    for (int f = 0; f < 30; f++) begin
      frame.delete();
      for (int i = 0; i < $urandom_range(1, 8); i++) frame.push_back(randElem());
      applyStimulus(w);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    // Backpressure: result must hold while a new operand waits.
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b0;
    frame = '{32'h41200000};
    applyStimulus(w);
    in_valid = 1'b1; in_data = 32'h3F800000; in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp in_ready", 32'({rdy0, rdy1}), 32'd0);
      checkOutput("bp out_valid", 32'(ov0), 32'd1);
      checkOutput("bp min_z stable", min0, 32'h41200000);
      checkOutput("bp max_z stable", max1, 32'h41200000);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("bp ready after handshake", 32'({rdy0, rdy1}), 32'b11);
    out_ready = 1'b1;
    frame = '{32'h3F800000, 32'hC0000000};
    applyStimulus(w);
    checkOutput("bp first accept wait", 32'(w), 32'd1);

    // Reset in the middle of a frame.
    sendOne(32'h40000000, 1'b0, w);
    sendOne(32'hC1000000, 1'b0, w);
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checkIdle("mid reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    frame = '{32'h3F000000, 32'hBF000000, 32'h3E800000};
    applyStimulus(w);

    g = 0;
    while ((q0.size() != 0 || q1.size() != 0) && g < 100) begin
      @(posedge clk);
      g++;
    end
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++; checks++;
      $display("[TB] FAIL drain: got %0d/%0d pending expected 0", q0.size(), q1.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp_minmax_reduce.md
# fp_minmax_reduce

Streaming floating-point reducer: consumes a frame of IEEE-754-format operands over a valid/ready stream and returns the frame minimum, maximum, their element indices, and element/NaN counts. It sits downstream of datapath producers, where a single pairwise FP compare cannot track a whole frame. Ordering is computed internally with the same rules as the library FP compare, so there is no external comparator instance.

## Interface
- sig_width, 23, fraction field width
- exp_width, 8, exponent field width
- ieee_compliance, 0, 0 = NaN/denormal-unaware ordering; 1 = IEEE NaN/denormal handling
- idx_width, 16, width of index and count fields
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand valid
- in_ready  output  1  block can accept an operand
- in_data  input  sig_width+exp_width+1  operand {sign, exp, frac}
- in_last  input  1  operand is the final element of the frame
- out_valid  output  1  frame result valid
- out_ready  input  1  consumer accepts the result
- min_z  output  sig_width+exp_width+1  frame minimum
- max_z  output  sig_width+exp_width+1  frame maximum
- min_idx  output  idx_width  index of min_z within the frame
- max_idx  output  idx_width  index of max_z within the frame
- count  output  idx_width  elements accepted in the frame, saturating
- nan_count  output  idx_width  NaN elements in the frame; always 0 when ieee_compliance=0
- all_nan  output  1  every element was NaN; ieee_compliance=1 only

## Operation
- States:
  - IDLE: no frame open, in_ready=1.
  - ACCUM: frame open, in_ready=1.
  - HOLD: result presented, in_ready=0, out_valid=1.
- Transitions:
  - An input accept (in_valid & in_ready) in IDLE opens a frame and moves to ACCUM, unless in_last is also set, which moves straight to HOLD.
  - An accept with in_last in ACCUM moves to HOLD.
  - HOLD & out_ready moves to IDLE.
- The first accepted non-NaN element loads min and max, with both indices set to its element index.
- Each later non-NaN element:
  - Replaces min only if strictly less than min.
  - Replaces max only if strictly greater than max.
  - On a tie the earlier element is kept.
- Ordering:
  - Sign-magnitude compare on {exp, frac}.
  - +0 and -0 compare equal.
  - exp all-ones is treated as infinity in magnitude order.
- ieee_compliance=0: no NaN detection. Denormals (exp=0) compare as zero, but the stored value is the received bits.
- ieee_compliance=1:
  - A NaN is exp all-ones with frac≠0.
  - NaN elements are counted in nan_count, not compared, and still consume an index.
  - Denormals are ordered exactly.
  - If every element is NaN, min_z = max_z = canonical qNaN {0, all-ones exp, frac MSB=1, rest 0}, both indices are 0, and all_nan=1.
- Element index starts at 0 per frame. count and the index counter saturate at 2^idx_width-1. Elements accepted after saturation are still compared and take the saturated index.

## Timing
- Reset values: in_ready=1, out_valid=0, all data, index and count outputs 0, all_nan=0, state IDLE.
- One operand per cycle is sustained while in_ready=1.
- out_valid rises on the cycle after the in_last accept. Result outputs are registered and stable throughout HOLD.
- In HOLD, in_valid is ignored and no operand is consumed.
- A new frame may be accepted on the cycle after the out handshake. Result registers clear when the next frame opens; outputs are don't-care while out_valid=0.
- An asynchronous reset mid-frame aborts the frame. All state returns to reset values and the next frame starts at index 0.
- out_ready while out_valid=0 has no effect.

## Test plan
- Basic frame:
  - Stimulus, single precision: 3F800000, C0000000, 40400000, 3F000000 (last).
  - Required: min_z=C0000000, min_idx=1; max_z=40400000, max_idx=2; count=4.
  - out_valid is high exactly 1 cycle after the last accept.
- Zero tie:
  - Stimulus: 00000000, 80000000 (last).
  - Required: min_z=max_z=00000000, both indices 0, count=2.
- Single-element frame:
  - Stimulus: 41200000 with last.
  - Required: min_z=max_z=41200000, indices 0, count=1. Back-to-back frames with out_ready=1 yield one result per frame.
- ieee_compliance=1 NaN handling:
  - Stimulus 1: 7FC00000, 3F800000, 7F800001 (last).
  - Required 1: min_z=max_z=3F800000, indices 1, nan_count=2, all_nan=0.
  - Stimulus 2: all-NaN frame of 3 elements.
  - Required 2: min_z=max_z=7FC00000, all_nan=1, count=3.
- Backpressure:
  - Stimulus: out_ready held low 5 cycles while in_valid=1.
  - Required: outputs stable and in_ready=0 throughout. After out_ready pulses, the first new element is accepted the next cycle with index 0.
- Reset mid-frame:
  - Stimulus: assert rst_n low after 2 accepts.
  - Required: out_valid=0 and all outputs 0 immediately. The following frame reports count from 0 and indices relative to its own start.
